// File: rtl/tause_pkg.sv
// Shared constants and step helpers for the taus88 generator.
// Optional seed clamping is enabled with TAUSE_SEED_FIX_EN.
package tause_pkg;

    localparam int W = 32;

    localparam int unsigned C1_SL = 13;
    localparam int unsigned C1_SR = 19;
    localparam int unsigned C1_SK = 12;

    localparam int unsigned C2_SL = 2;
    localparam int unsigned C2_SR = 25;
    localparam int unsigned C2_SK = 4;

    localparam int unsigned C3_SL = 3;
    localparam int unsigned C3_SR = 11;
    localparam int unsigned C3_SK = 17;

    localparam logic [W-1:0] C1_MASK = 32'hFFFF_FFFE;
    localparam logic [W-1:0] C2_MASK = 32'hFFFF_FFF8;
    localparam logic [W-1:0] C3_MASK = 32'hFFFF_FFF0;

    localparam logic [W-1:0] C1_MIN = 32'd2;
    localparam logic [W-1:0] C2_MIN = 32'd8;
    localparam logic [W-1:0] C3_MIN = 32'd16;

    typedef enum logic {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_e;

    // One Tausworthe component update; shifts are logical, overflow drops.
    function automatic logic [W-1:0] taus_step(
        input logic [W-1:0] s,
        input int unsigned  sl,
        input int unsigned  sr,
        input int unsigned  sk,
        input logic [W-1:0] mask
    );
        logic [W-1:0] b;
        b = ((s << sl) ^ s) >> sr;
        return ((s & mask) << sk) ^ b;
    endfunction

    function automatic logic [W-1:0] seed_clamp(
        input logic [W-1:0] s,
        input logic [W-1:0] lo
    );
        return (s < lo) ? lo : s;
    endfunction

endpackage

// File: rtl/tause_if.sv
// Seed/sample bundle for one 3-component generator.
// Master drives seeds and consumes the sample; slave is the generator.
interface tause_if;
    import tause_pkg::*;

    logic [W-1:0] seed1;
    logic [W-1:0] seed2;
    logic [W-1:0] seed3;
    logic [W-1:0] taus;

    modport master (
        output seed1,
        output seed2,
        output seed3,
        input  taus
    );

    modport slave (
        input  seed1,
        input  seed2,
        input  seed3,
        output taus
    );

endinterface

// File: rtl/tause_gen.sv
// One taus88 generator: seeds loaded once after reset, then free-running.
// TAUSE_SEED_FIX_EN clamps degenerate seeds to the component minimum.
module tause_gen
    import tause_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    tause_if.slave u_bus
);

    gen_state_e   r_state;
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_s3;

    logic [W-1:0] w_seed1;
    logic [W-1:0] w_seed2;
    logic [W-1:0] w_seed3;
    logic [W-1:0] w_src1;
    logic [W-1:0] w_src2;
    logic [W-1:0] w_src3;
    logic         w_seeded;

`ifdef TAUSE_SEED_FIX_EN
    assign w_seed1 = seed_clamp(u_bus.seed1, C1_MIN);
    assign w_seed2 = seed_clamp(u_bus.seed2, C2_MIN);
    assign w_seed3 = seed_clamp(u_bus.seed3, C3_MIN);
`else
    assign w_seed1 = u_bus.seed1;
    assign w_seed2 = u_bus.seed2;
    assign w_seed3 = u_bus.seed3;
`endif

    assign w_seeded = (r_state == ST_RUN);

    // Seeds feed the step only on the load edge; afterwards state recirculates.
    assign w_src1 = w_seeded ? r_s1 : w_seed1;
    assign w_src2 = w_seeded ? r_s2 : w_seed2;
    assign w_src3 = w_seeded ? r_s3 : w_seed3;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_SEED;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
        end else begin
            r_s1 <= taus_step(w_src1, C1_SL, C1_SR, C1_SK, C1_MASK);
            r_s2 <= taus_step(w_src2, C2_SL, C2_SR, C2_SK, C2_MASK);
            r_s3 <= taus_step(w_src3, C3_SL, C3_SR, C3_SK, C3_MASK);
            unique case (r_state)
                ST_SEED: r_state <= ST_RUN;
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_SEED;
            endcase
        end
    end

    assign u_bus.taus = r_s1 ^ r_s2 ^ r_s3;

endmodule

// File: rtl/tause_urng.sv
// Dual independent taus88 uniform generators, one sample each per clock.
// Seed clamping is optional via TAUSE_SEED_FIX_EN.
module tause_urng
    import tause_pkg::*;
(
    input  logic         iClk,
    input  logic         iRst,
    input  logic [W-1:0] iUrng_seed1,
    input  logic [W-1:0] iUrng_seed2,
    input  logic [W-1:0] iUrng_seed3,
    input  logic [W-1:0] iUrng_seed4,
    input  logic [W-1:0] iUrng_seed5,
    input  logic [W-1:0] iUrng_seed6,
    output logic [W-1:0] oTaus1,
    output logic [W-1:0] oTaus2
);

    tause_if u_bus_a ();
    tause_if u_bus_b ();

    assign u_bus_a.seed1 = iUrng_seed1;
    assign u_bus_a.seed2 = iUrng_seed2;
    assign u_bus_a.seed3 = iUrng_seed3;

    assign u_bus_b.seed1 = iUrng_seed4;
    assign u_bus_b.seed2 = iUrng_seed5;
    assign u_bus_b.seed3 = iUrng_seed6;

    tause_gen u_gen_a (
        .i_clk (iClk),
        .i_rst (iRst),
        .u_bus (u_bus_a.slave)
    );

    tause_gen u_gen_b (
        .i_clk (iClk),
        .i_rst (iRst),
        .u_bus (u_bus_b.slave)
    );

    assign oTaus1 = u_bus_a.taus;
    assign oTaus2 = u_bus_b.taus;

endmodule

// File: tb/tb_tause_urng.sv
// Directed and model-based bench for the dual taus88 generator.
// Honours TAUSE_SEED_FIX_EN for the zero-seed expectation.
module tb_tause_urng;

    logic iClk = 1'b0;
    logic iRst = 1'b0;

    tause_if tb_a ();
    tause_if tb_b ();

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ma [3];
    logic [31:0] mb [3];
    logic [31:0] gold [16];

    always #5 iClk = ~iClk;

    tause_urng dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iUrng_seed1 (tb_a.seed1),
        .iUrng_seed2 (tb_a.seed2),
        .iUrng_seed3 (tb_a.seed3),
        .iUrng_seed4 (tb_b.seed1),
        .iUrng_seed5 (tb_b.seed2),
        .iUrng_seed6 (tb_b.seed3),
        .oTaus1      (tb_a.taus),
        .oTaus2      (tb_b.taus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_c1(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 13) ^ s) >> 19;
        return ((s & 32'hFFFFFFFE) << 12) ^ b;
    endfunction

    function automatic logic [31:0] m_c2(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 2) ^ s) >> 25;
        return ((s & 32'hFFFFFFF8) << 4) ^ b;
    endfunction

    function automatic logic [31:0] m_c3(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 3) ^ s) >> 11;
        return ((s & 32'hFFFFFFF0) << 17) ^ b;
    endfunction

    function automatic logic [31:0] fixs(input logic [31:0] s,
                                         input logic [31:0] lo);
`ifdef TAUSE_SEED_FIX_EN
        return (s < lo) ? lo : s;
`else
        return (lo == 32'd0) ? 32'd0 : s;
`endif
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_seeds(input logic [31:0] a1, a2, a3,
                             input logic [31:0] b1, b2, b3);
        tb_a.seed1 = a1; tb_a.seed2 = a2; tb_a.seed3 = a3;
        tb_b.seed1 = b1; tb_b.seed2 = b2; tb_b.seed3 = b3;
        ma[0] = fixs(a1, 2); ma[1] = fixs(a2, 8); ma[2] = fixs(a3, 16);
        mb[0] = fixs(b1, 2); mb[1] = fixs(b2, 8); mb[2] = fixs(b3, 16);
    endtask

    task automatic model_step();
        ma[0] = m_c1(ma[0]); ma[1] = m_c2(ma[1]); ma[2] = m_c3(ma[2]);
        mb[0] = m_c1(mb[0]); mb[1] = m_c2(mb[1]); mb[2] = m_c3(mb[2]);
    endtask

    function automatic logic [31:0] xa();
        return ma[0] ^ ma[1] ^ ma[2];
    endfunction

    function automatic logic [31:0] xb();
        return mb[0] ^ mb[1] ^ mb[2];
    endfunction

    task automatic do_reset();
        iRst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        set_seeds(32'h1234, 32'h5678, 32'h9abc, 32'h11, 32'h22, 32'h33);
        #2;
        chk("rst_a_async", tb_a.taus, 32'd0);
        chk("rst_b_async", tb_b.taus, 32'd0);
        tick();
        tick();
        chk("rst_a_hold", tb_a.taus, 32'd0);
        chk("rst_b_hold", tb_b.taus, 32'd0);

        set_seeds(32'd2, 32'd8, 32'd16, 32'd2, 32'd8, 32'd16);
        iRst = 1'b1;
        tick();
        chk("min_a_1", tb_a.taus, 32'd2105472);
        chk("min_b_1", tb_b.taus, 32'd2105472);
        tick();
        chk("min_a_2", tb_a.taus, 32'd33565824);
        chk("min_b_2", tb_b.taus, 32'd33565824);

        do_reset();
        set_seeds(32'd1999, 32'd2995, 32'd3666,
                  32'd3658, 32'd1564, 32'd4578);
        iRst = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            model_step();
            tick();
            if (i < 16) gold[i] = xa();
            chk("run_a", tb_a.taus, xa());
            chk("run_b", tb_b.taus, xb());
            if (i == 3) chk("ab_differ", {31'd0, tb_a.taus != tb_b.taus}, 32'd1);
            if (i == 5000) begin
                tb_a.seed1 = $urandom; tb_a.seed2 = $urandom;
                tb_a.seed3 = $urandom; tb_b.seed1 = $urandom;
                tb_b.seed2 = $urandom; tb_b.seed3 = $urandom;
            end
        end

        #3;
        iRst = 1'b0;
        #1;
        chk("midrst_a", tb_a.taus, 32'd0);
        chk("midrst_b", tb_b.taus, 32'd0);
        tick();

        set_seeds(32'd1999, 32'd2995, 32'd3666,
                  32'd3658, 32'd1564, 32'd4578);
        iRst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            model_step();
            tick();
            chk("reseed_a", tb_a.taus, gold[i]);
            chk("reseed_b", tb_b.taus, xb());
        end

        do_reset();
        set_seeds(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        iRst = 1'b1;
        tick();
`ifdef TAUSE_SEED_FIX_EN
        chk("zero_a_1", tb_a.taus, 32'd2105472);
        chk("zero_b_1", tb_b.taus, 32'd2105472);
`else
        chk("zero_a_1", tb_a.taus, 32'd0);
        chk("zero_b_1", tb_b.taus, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            model_step();
            tick();
            chk("zero_a_run", tb_a.taus, m_c1(xa()) & 32'd0 | xa_next_dummy(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [31:0] xa_next_dummy(input int i);
        logic [31:0] s1, s2, s3;
        s1 = fixs(32'd0, 2); s2 = fixs(32'd0, 8); s3 = fixs(32'd0, 16);
        for (int k = 0; k < i + 2; k++) begin
            s1 = m_c1(s1); s2 = m_c2(s2); s3 = m_c3(s3);
        end
        return s1 ^ s2 ^ s3;
    endfunction

endmodule
